addsub_pipe: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's 32-bit combinational FA block.
- Produces the same flag set: OF, CF, ZF, SF, PF.
- Operands are split into SEG-bit segments and added one segment per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides. Sits between the register-file read stage and the writeback/flags logic of the ALU datapath.

---
 rtl/addsub_pipe.sv | 114 +++++++++++
 tb/tb_addsub_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor, SEG bits per stage.
// Level 0 captures the operands; stage k adds segment k and passes the carry on.
// The final stage writes the result and flags straight into the output registers.
module addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             OF,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             PF
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  // Reject widths the segmented datapath cannot represent.
  if (((WIDTH % SEG) != 0) || (WIDTH < 8)) begin : g_param_check
    $fatal(1, "addsub_pipe: WIDTH must be a multiple of SEG and at least 8");
  end

  // Per-level state. x_q holds finished result segments below the current
  // stage and still-unadded A segments above it; b_q is the (possibly
  // inverted) B operand; cy_q is the carry entering the current stage.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ctrl_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  x_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];

  logic [SEG:0]      sum_c   [STAGES];
  logic [WIDTH-1:0]  x_nxt_c [STAGES];

  logic              adv_c;
  logic              c_out_c;
  logic              c_msb_c;
  logic [WIDTH-1:0]  r_c;

  // Whole pipe moves together unless a valid result is waiting on downstream.
  assign adv_c    = ~out_valid | out_ready;
  assign in_ready = adv_c;

  // Segment adders: each stage adds its own slice plus the registered carry.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum_c[k]   = {1'b0, x_q[k][k*SEG +: SEG]}
                 + {1'b0, b_q[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, cy_q[k]};
      x_nxt_c[k] = x_q[k];
      x_nxt_c[k][k*SEG +: SEG] = sum_c[k][SEG-1:0];
    end
  end

  // Final-stage result and the two carries that drive CF and OF.
  always_comb begin
    r_c     = x_nxt_c[LAST];
    c_out_c = sum_c[LAST][SEG];
    c_msb_c = x_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ r_c[WIDTH-1];
  end

  // Pipeline registers: capture level, inter-stage shift, output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      ctrl_q    <= '0;
      cy_q      <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        b_q[k] <= '0;
      end
      out_valid <= 1'b0;
      s         <= '0;
      OF        <= 1'b0;
      CF        <= 1'b0;
      ZF        <= 1'b0;
      SF        <= 1'b0;
      PF        <= 1'b0;
    end else if (adv_c) begin
      v_q[0]    <= in_valid;
      ctrl_q[0] <= Ctrl;
      cy_q[0]   <= Ctrl;
      x_q[0]    <= A;
      b_q[0]    <= Ctrl ? ~B : B;
      for (int unsigned k = 0; k < LAST; k++) begin
        v_q[k+1]    <= v_q[k];
        ctrl_q[k+1] <= ctrl_q[k];
        cy_q[k+1]   <= sum_c[k][SEG];
        x_q[k+1]    <= x_nxt_c[k];
        b_q[k+1]    <= b_q[k];
      end
      out_valid <= v_q[LAST];
      if (v_q[LAST]) begin
        s  <= r_c;
        OF <= c_out_c ^ c_msb_c;
        CF <= c_out_c ^ ctrl_q[LAST];
        ZF <= (r_c == '0);
        SF <= r_c[WIDTH-1];
        PF <= ~^r_c[7:0];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, SEG=8).
module tb_addsub_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SEG    = 8;
  localparam int unsigned LAT    = WIDTH / SEG;
  localparam longint      SMAX   = 64'sd2147483647;
  localparam longint      SMIN   = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             Ctrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             OF, CF, ZF, SF, PF;

  addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ctrl(Ctrl), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .OF(OF), .CF(CF), .ZF(ZF), .SF(SF), .PF(PF)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic             ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             ovf, cf, zf, sf, pf;
  } vec_t;

  typedef struct {
    vec_t        v;
    int unsigned acc_edge;
    bit          lat_chk;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic vec_t ref_model(input logic ctrl, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    vec_t   r;
    longint sa, sb, sr;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sr = ctrl ? (sa - sb) : (sa + sb);
    r.ctrl = ctrl;
    r.a    = a;
    r.b    = b;
    r.s    = ctrl ? (a - b) : (a + b);
    r.cf   = ctrl ? (ua < ub) : ((ua + ub) > 64'sd4294967295);
    r.ovf  = (sr > SMAX) || (sr < SMIN);
    r.zf   = (r.s == '0);
    r.sf   = r.s[WIDTH-1];
    r.pf   = ($countones(r.s[7:0]) % 2) == 0;
    return r;
  endfunction

  // One clock: drive at the falling edge, then check outputs and track handshakes.
  task automatic cycle(input bit iv, input vec_t ev, input bit ordy, input bit lat_chk);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    Ctrl      = ev.ctrl;
    A         = ev.a;
    B         = ev.b;
    out_ready = ordy;
    #1;
    chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("out_valid_unexpected", 64'(out_valid), 64'd0);
      end else begin
        chk("s", 64'(s), 64'(sbq[0].v.s));
        chk("flags_of_cf_zf_sf_pf", 64'({OF, CF, ZF, SF, PF}),
            64'({sbq[0].v.ovf, sbq[0].v.cf, sbq[0].v.zf, sbq[0].v.sf, sbq[0].v.pf}));
        if (out_ready) begin
          if (sbq[0].lat_chk)
            chk("latency", 64'(edge_cnt - sbq[0].acc_edge), 64'(LAT));
          void'(sbq.pop_front());
        end
      end
    end
    if (in_valid && in_ready) begin
      e.v        = ev;
      e.acc_edge = edge_cnt + 1;
      e.lat_chk  = lat_chk;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    vec_t idle;
    idle = ref_model(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      cycle(1'b0, idle, 1'b1, 1'b1);
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  vec_t tbl[4];
  vec_t v;
  vec_t idle;

  initial begin
    // Directed vectors with hand-derived expectations.
    tbl[0] = '{ctrl:1'b0, a:32'h4BDE5515, b:32'hD7451D52, s:32'h23237267,
               ovf:1'b0, cf:1'b1, zf:1'b0, sf:1'b0, pf:1'b0};
    tbl[1] = '{ctrl:1'b1, a:32'h4BDE5515, b:32'hD7451D52, s:32'h749937C3,
               ovf:1'b0, cf:1'b1, zf:1'b0, sf:1'b0, pf:1'b1};
    tbl[2] = '{ctrl:1'b0, a:32'h7FFFFFFF, b:32'h00000001, s:32'h80000000,
               ovf:1'b1, cf:1'b0, zf:1'b0, sf:1'b1, pf:1'b1};
    tbl[3] = '{ctrl:1'b1, a:32'h00000005, b:32'h00000005, s:32'h00000000,
               ovf:1'b0, cf:1'b0, zf:1'b1, sf:1'b0, pf:1'b1};
    idle = ref_model(1'b0, '0, '0);

    rst = 1'b1; in_valid = 1'b0; Ctrl = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_flags", 64'({OF, CF, ZF, SF, PF}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed table, one beat at a time.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, tbl[i], 1'b1, 1'b1);
      drain();
    end

    // Back-to-back random beats, alternating add/sub, full throughput.
    for (int i = 0; i < 8; i++) begin
      v = ref_model(i[0], $urandom(), $urandom());
      cycle(1'b1, v, 1'b1, 1'b1);
    end
    drain();

    // Mid-stream stall: six cycles of out_ready=0 with input still offered.
    for (int i = 0; i < 19; i++) begin
      v = ref_model(1'($urandom_range(0, 1)), rand_operand(), rand_operand());
      cycle(1'b1, v, !(i >= 5 && i < 11), 1'b0);
    end
    drain();

    // Random valid/ready traffic with corner-heavy operands.
    for (int i = 0; i < 200; i++) begin
      v = ref_model(1'($urandom_range(0, 1)), rand_operand(), rand_operand());
      cycle(1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    // Reset with several beats in flight, then a clean beat afterwards.
    for (int i = 0; i < 6; i++) begin
      v = ref_model(1'($urandom_range(0, 1)), $urandom(), $urandom());
      cycle(1'b1, v, 1'b1, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_flags", 64'({OF, CF, ZF, SF, PF}), 64'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, tbl[1], 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
